// File: rtl/mem_access_ctrl.sv
// Multicycle load/store sequencer for a single-port data memory.
// Sub-word stores use read-modify-write because the memory lacks byte enables.
module mem_access_ctrl #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mdr_load,
  output logic [1:0]  load_size,
  output logic        resp_valid,
  output logic        resp_error
);

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, LATCH, WR, RESP
  } state_t;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        write_q;
  logic [1:0]  size_q;
  logic [15:0] wdata_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        mem_wr_q;
  logic        mdr_load_q;
  logic [1:0]  load_size_q;
  logic        resp_valid_q;
  logic        resp_error_q;

  logic [31:0] mask_d;
  logic [31:0] merged_d;

  // Byte stores replace bits 7:0, half stores bits 15:0.
  always_comb begin
    mask_d = (size_q == 2'b11) ? 32'h0000_00ff
                               : 32'h0000_ffff;
    merged_d = (mem_rdata & ~mask_d)
             | ({16'h0, wdata_q} & mask_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      size_q       <= '0;
      wdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wr_q     <= 1'b0;
      mdr_load_q   <= 1'b0;
      load_size_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
    end else begin
      mem_wr_q     <= 1'b0;
      mdr_load_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q      <= req_write;
            size_q       <= req_size;
            wdata_q      <= req_wdata[15:0];
            mem_addr_q   <= req_addr;
            resp_error_q <= 1'b0;
            if (req_size == 2'b00) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
            end else if (req_write && req_size == 2'b01) begin
              state_q     <= WR;
              mem_wr_q    <= 1'b1;
              mem_wdata_q <= req_wdata;
            end else begin
              state_q <= RD_WAIT;
              cnt_q   <= LAT;
              if (!req_write) load_size_q <= req_size;
            end
          end
        end
        RD_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_q    <= LATCH;
            mdr_load_q <= !write_q;
          end
        end
        LATCH: begin
          if (write_q) begin
            state_q     <= WR;
            mem_wr_q    <= 1'b1;
            mem_wdata_q <= merged_d;
          end else begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
          end
        end
        WR: begin
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
        end
        RESP: begin
          state_q      <= IDLE;
          load_size_q  <= 2'b00;
          resp_error_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE) && !reset;
  assign mem_addr   = mem_addr_q;
  assign mem_wr     = mem_wr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mdr_load   = mdr_load_q;
  assign load_size  = load_size_q;
  assign resp_valid = resp_valid_q;
  assign resp_error = resp_error_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: one instance at MEM_LAT=1, one at 2,
// each fed by a small latency-accurate read model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        rv1, rv2;
  logic        req_write;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic        rdy1, mw1, ml1, resp_v1, resp_e1;
  logic [31:0] ma1, mwd1, rd1;
  logic [1:0]  ls1;
  logic        rdy2, mw2, ml2, resp_v2, resp_e2;
  logic [31:0] ma2, mwd2, rd2;
  logic [1:0]  ls2;

  logic [31:0] mem [16];
  logic [31:0] p1a, p2a, p2b;

  int vec = 0;
  int err = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.MEM_LAT(1)) u1 (
    .clk(clk), .reset(reset),
    .req_valid(rv1), .req_ready(rdy1),
    .req_write(req_write), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_addr(ma1), .mem_wr(mw1),
    .mem_wdata(mwd1), .mem_rdata(rd1),
    .mdr_load(ml1), .load_size(ls1),
    .resp_valid(resp_v1), .resp_error(resp_e1)
  );

  mem_access_ctrl #(.MEM_LAT(2)) u2 (
    .clk(clk), .reset(reset),
    .req_valid(rv2), .req_ready(rdy2),
    .req_write(req_write), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_addr(ma2), .mem_wr(mw2),
    .mem_wdata(mwd2), .mem_rdata(rd2),
    .mdr_load(ml2), .load_size(ls2),
    .resp_valid(resp_v2), .resp_error(resp_e2)
  );

  // Read data appears MEM_LAT cycles after the address.
  always @(posedge clk) begin
    p1a <= ma1;
    p2a <= ma2;
    p2b <= p2a;
  end
  assign rd1 = mem[p1a[5:2]];
  assign rd2 = mem[p2b[5:2]];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
    req_write = w;
    req_size  = sz;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    rv1 = 1'b0;
    rv2 = 1'b0;
    set_req(1'b0, 2'b00, 32'h0, 32'h0);
    tick;
    tick;
    vec++;
    if ({ma1, mwd1, mw1, ml1, ls1, resp_v1, resp_e1, rdy1} !== 71'h0) begin
      err++;
      $display("FAIL reset_u1: got ma=%h wd=%h ctl=%b rdy=%b want 0",
               ma1, mwd1, {mw1, ml1, ls1, resp_v1, resp_e1}, rdy1);
    end
    vec++;
    if ({ma2, mwd2, mw2, ml2, ls2, resp_v2, resp_e2, rdy2} !== 71'h0) begin
      err++;
      $display("FAIL reset_u2: got ma=%h wd=%h ctl=%b rdy=%b want 0",
               ma2, mwd2, {mw2, ml2, ls2, resp_v2, resp_e2}, rdy2);
    end
    reset = 1'b0;
    #1;
    vec++;
    if ({rdy1, rdy2} !== 2'b11) begin
      err++;
      $display("FAIL ready_after_reset: got %b want 11", {rdy1, rdy2});
    end
  endtask

  // Control vector per cycle: {mem_wr, mdr_load, load_size, resp_valid, resp_error}
  task automatic test_load_word;
    logic [5:0] e [4];
    e = '{6'b000100, 6'b010100, 6'b000110, 6'b000000};
    mem[0] = 32'hDEADBEEF;
    set_req(1'b0, 2'b01, 32'h40, 32'h0);
    rv1 = 1'b1;
    vec++;
    if (rdy1 !== 1'b1) begin
      err++;
      $display("FAIL load_ready: got %b want 1", rdy1);
    end
    tick;
    rv1 = 1'b0;
    vec++;
    if (ma1 !== 32'h40) begin
      err++;
      $display("FAIL load_addr: got %h want 00000040", ma1);
    end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick;
      vec++;
      if ({mw1, ml1, ls1, resp_v1, resp_e1} !== e[k]) begin
        err++;
        $display("FAIL load_ctl T+%0d: got %b want %b",
                 k + 1, {mw1, ml1, ls1, resp_v1, resp_e1}, e[k]);
      end
      if (k == 1 && rd1 !== 32'hDEADBEEF) begin
        vec++;
        err++;
        $display("FAIL load_rdata: got %h want deadbeef", rd1);
      end
    end
    vec++;
    if (ma1 !== 32'h40 || rdy1 !== 1'b1) begin
      err++;
      $display("FAIL load_hold: got ma=%h rdy=%b want 00000040/1", ma1, rdy1);
    end
  endtask

  task automatic rmw_store(input string nm, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] old,
                           input logic [31:0] d, input logic [31:0] want);
    logic [5:0] e [6];
    e = '{6'b0, 6'b0, 6'b0, 6'b100000, 6'b000010, 6'b0};
    mem[a[5:2]] = old;
    set_req(1'b1, sz, a, d);
    rv2 = 1'b1;
    tick;
    rv2 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick;
      vec++;
      if ({mw2, ml2, ls2, resp_v2, resp_e2} !== e[k]) begin
        err++;
        $display("FAIL %s_ctl T+%0d: got %b want %b", nm,
                 k + 1, {mw2, ml2, ls2, resp_v2, resp_e2}, e[k]);
      end
      if (k == 3) begin
        vec++;
        if (mwd2 !== want || ma2 !== a) begin
          err++;
          $display("FAIL %s_wdata: got %h@%h want %h@%h",
                   nm, mwd2, ma2, want, a);
        end
      end
    end
  endtask

  task automatic test_byte_store;
    rmw_store("byte", 2'b11, 32'h84, 32'h11223344,
              32'h000000AB, 32'h112233AB);
  endtask

  task automatic test_half_word_store;
    rmw_store("half", 2'b10, 32'h88, 32'hAAAABBBB,
              32'hFFFF1234, 32'hAAAA1234);
    set_req(1'b1, 2'b01, 32'h10, 32'hCAFEF00D);
    rv1 = 1'b1;
    tick;
    rv1 = 1'b0;
    vec++;
    if ({mw1, ml1, ls1, resp_v1} !== 5'b10000 || mwd1 !== 32'hCAFEF00D
        || ma1 !== 32'h10) begin
      err++;
      $display("FAIL word_wr: got ctl=%b wd=%h@%h want 10000 cafef00d@10",
               {mw1, ml1, ls1, resp_v1}, mwd1, ma1);
    end
    tick;
    vec++;
    if ({mw1, resp_v1, resp_e1} !== 3'b010) begin
      err++;
      $display("FAIL word_resp: got %b want 010", {mw1, resp_v1, resp_e1});
    end
    tick;
    vec++;
    if ({mw1, resp_v1, rdy1} !== 3'b001) begin
      err++;
      $display("FAIL word_idle: got %b want 001", {mw1, resp_v1, rdy1});
    end
  endtask

  task automatic test_illegal;
    set_req(1'b1, 2'b00, 32'h44, 32'h1);
    rv1 = 1'b1;
    tick;
    rv1 = 1'b0;
    vec++;
    if ({mw1, ml1, ls1, resp_v1, resp_e1} !== 6'b000011) begin
      err++;
      $display("FAIL illegal_resp: got %b want 000011",
               {mw1, ml1, ls1, resp_v1, resp_e1});
    end
    tick;
    vec++;
    if ({mw1, ml1, ls1, resp_v1, resp_e1, rdy1} !== 7'b0000001) begin
      err++;
      $display("FAIL illegal_after: got %b want 0000001",
               {mw1, ml1, ls1, resp_v1, resp_e1, rdy1});
    end
  endtask

  task automatic test_back_to_back;
    mem[0] = 32'h01020304;
    set_req(1'b0, 2'b01, 32'h40, 32'h0);
    rv1 = 1'b1;
    tick;
    set_req(1'b1, 2'b01, 32'h20, 32'h55AA55AA);
    for (int k = 1; k <= 3; k++) begin
      vec++;
      if (rdy1 !== 1'b0 || mw1 !== 1'b0) begin
        err++;
        $display("FAIL b2b_busy T+%0d: got rdy=%b wr=%b want 0/0",
                 k, rdy1, mw1);
      end
      tick;
    end
    vec++;
    if (rdy1 !== 1'b1 || resp_v1 !== 1'b0) begin
      err++;
      $display("FAIL b2b_ready T+4: got rdy=%b rv=%b want 1/0", rdy1, resp_v1);
    end
    tick;
    rv1 = 1'b0;
    vec++;
    if (mw1 !== 1'b1 || ma1 !== 32'h20 || mwd1 !== 32'h55AA55AA) begin
      err++;
      $display("FAIL b2b_second: got wr=%b %h@%h want 1 55aa55aa@20",
               mw1, mwd1, ma1);
    end
    tick;
    vec++;
    if (resp_v1 !== 1'b1) begin
      err++;
      $display("FAIL b2b_resp: got %b want 1", resp_v1);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    mem[1] = 32'h11223344;
    set_req(1'b1, 2'b11, 32'h84, 32'h00000099);
    rv2 = 1'b1;
    tick;
    rv2 = 1'b0;
    reset = 1'b1;
    tick;
    vec++;
    if ({ma2, mwd2, mw2, ml2, ls2, resp_v2, resp_e2, rdy2} !== 71'h0) begin
      err++;
      $display("FAIL mid_reset: got ma=%h wd=%h ctl=%b rdy=%b want 0",
               ma2, mwd2, {mw2, ml2, ls2, resp_v2, resp_e2}, rdy2);
    end
    set_req(1'b1, 2'b01, 32'h30, 32'h00000077);
    rv2 = 1'b1;
    tick;
    rv2 = 1'b0;
    reset = 1'b0;
    #1;
    vec++;
    if (mw2 !== 1'b0 || ma2 !== 32'h0 || rdy2 !== 1'b1) begin
      err++;
      $display("FAIL reset_wins: got wr=%b ma=%h rdy=%b want 0/0/1",
               mw2, ma2, rdy2);
    end
    for (int k = 0; k < 6; k++) begin
      tick;
      vec++;
      if (mw2 !== 1'b0 || resp_v2 !== 1'b0) begin
        err++;
        $display("FAIL mid_silent +%0d: got wr=%b rv=%b want 0/0",
                 k, mw2, resp_v2);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    test_reset;
    test_load_word;
    test_byte_store;
    test_half_word_store;
    test_illegal;
    test_back_to_back;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
